serial_code_controller: RTL and testbench
=========================================

Name: serial_code_controller

Overview:
Sequencer that drives a serial sequence detector (green/red code-lock style) from a parallel code word. On each attempt it clears the detector, shifts the captured code out serially MSB-first, samples the detector's match output, and tracks pass/fail. After MAX_FAIL consecutive failures it enforces a lockout period. It sits between the user-entry logic and the detector instance at the top level.

Parameters:
CODE_W, 4, number of code bits shifted per attempt (2..16)
MAX_FAIL, 3, consecutive failures that trigger lockout (1..15)
LOCK_CYCLES, 16, lockout duration in clock cycles (1..65535)

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  begin attempt; sampled only in IDLE
code_in  input  CODE_W  attempt code, captured on the start-accept edge
relock  input  1  leave PASS and return to IDLE
det_g  input  1  detector match/green output
det_in  output  1  serial bit to detector
det_rst_n  output  1  active-low reset to detector
busy  output  1  high in any state other than IDLE and PASS
unlocked  output  1  high while in PASS
fail  output  1  one-cycle pulse in FAIL state
lockout  output  1  high while in LOCKOUT
fail_count  output  4  consecutive failure count

Behaviour:
- States: IDLE, CLEAR, SHIFT, CHECK, PASS, FAIL, LOCKOUT. Registered state; all outputs decoded from registered state/counters (Moore).
- Reset (async, any time, including mid-shift): state=IDLE, shift reg=0, bit counter=0, fail_count=0, lock counter=0. Outputs: det_in=1, det_rst_n=0, busy=0, unlocked=0, fail=0, lockout=0.
- det_rst_n=1 only in SHIFT and CHECK; 0 in every other state. det_in = shift reg MSB in SHIFT, 1 otherwise.
- IDLE: start=1 -> capture code_in into shift reg, go CLEAR. Otherwise stay.
- CLEAR: 1 cycle, detector held in reset -> SHIFT with bit counter=0.
- SHIFT: exactly CODE_W cycles; each edge shifts reg left by 1 (zero fill), increments counter; after CODE_W-th edge -> CHECK.
- CHECK: 1 cycle; det_g=1 -> PASS, else -> FAIL.
- Latency: start sampled at edge 0 -> unlocked (or fail) high after edge CODE_W+2.
- PASS: fail_count cleared on entry; unlocked=1; stays until relock=1 -> IDLE. start ignored in PASS (relock wins if both high).
- FAIL: 1 cycle, fail=1; fail_count increments (saturating at 15). If new count >= MAX_FAIL -> LOCKOUT with lock counter=0, else -> IDLE.
- LOCKOUT: lockout=1 for exactly LOCK_CYCLES cycles; on exit fail_count=0 -> IDLE. start ignored.
- start, code_in, relock ignored outside the states named above; code_in changes after capture have no effect.
- det_g ignored outside CHECK.

Test Plan:
- CODE_W=4, code_in=4'b0110, start pulse, detector model attached -> det_in sequence 0,1,1,0 during SHIFT; unlocked=1 after edge 6; fail_count=0; relock -> IDLE, unlocked=0 next cycle.
- code_in=4'b1111 three times (MAX_FAIL=3) -> fail pulses with fail_count 1,2,3; lockout=1 for exactly 16 cycles; then fail_count=0, IDLE; start during lockout ignored.
- Two fails then correct 0110 -> fail_count 2 then cleared to 0 on PASS entry; no lockout.
- reset asserted during 2nd SHIFT cycle -> immediately IDLE, det_rst_n=0, busy=0, fail_count=0; next start runs a full clean attempt.
- start held high and code_in toggled during SHIFT -> single attempt, shifted bits equal code captured at accept edge; in PASS with start=1 and relock=1 together -> IDLE, no new attempt that cycle.
- det_g forced high outside CHECK (e.g. in CLEAR/SHIFT) with wrong code -> still FAIL; det_rst_n low in IDLE/CLEAR/PASS/FAIL/LOCKOUT verified every cycle.

Source files
------------

// File: rtl/serial_code_controller.sv
// Sequencer that shifts a captured parallel code into a serial sequence detector,
// checks the match result and enforces a lockout after repeated failures.
module serial_code_controller #(
  parameter int unsigned CODE_W      = 4,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CODE_W-1:0] code_in,
  input  logic              relock,
  input  logic              det_g,
  output logic              det_in,
  output logic              det_rst_n,
  output logic              busy,
  output logic              unlocked,
  output logic              fail,
  output logic              lockout,
  output logic [3:0]        fail_count
);

  localparam int unsigned CntW = $clog2(CODE_W + 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StShift,
    StCheck,
    StPass,
    StFail,
    StLockout
  } state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]        fail_cnt_q, fail_cnt_d;
  logic [15:0]       lock_cnt_q, lock_cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      fail_cnt_q <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    fail_cnt_d = fail_cnt_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          shift_d = code_in;
          state_d = StClear;
        end
      end
      StClear: begin
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CntW'(CODE_W - 1)) state_d = StCheck;
      end
      StCheck: begin
        // Count is updated on entry so it is visible alongside the fail pulse.
        if (det_g) begin
          fail_cnt_d = '0;
          state_d    = StPass;
        end else begin
          fail_cnt_d = (fail_cnt_q == 4'hf) ? fail_cnt_q : fail_cnt_q + 4'd1;
          state_d    = StFail;
        end
      end
      StPass: begin
        if (relock) state_d = StIdle;
      end
      StFail: begin
        if (fail_cnt_q >= 4'(MAX_FAIL)) begin
          lock_cnt_d = '0;
          state_d    = StLockout;
        end else begin
          state_d = StIdle;
        end
      end
      StLockout: begin
        if (lock_cnt_q == 16'(LOCK_CYCLES - 1)) begin
          fail_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          lock_cnt_d = lock_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign det_in     = (state_q == StShift) ? shift_q[CODE_W-1] : 1'b1;
  assign det_rst_n  = (state_q == StShift) || (state_q == StCheck);
  assign busy       = (state_q != StIdle) && (state_q != StPass);
  assign unlocked   = (state_q == StPass);
  assign fail       = (state_q == StFail);
  assign lockout    = (state_q == StLockout);
  assign fail_count = fail_cnt_q;

endmodule

// File: tb/tb_serial_code_controller.sv
// Directed bench for serial_code_controller with a 0110 detector model and a
// scoreboard of expected serial bits and attempt outcomes.
module tb_serial_code_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] code_in = '0;
  logic       relock = 1'b0;
  logic       det_g;
  logic       det_in, det_rst_n, busy, unlocked, fail, lockout;
  logic [3:0] fail_count;

  logic       det_force = 1'b0;
  logic [3:0] det_sr;

  int n_checks = 0;
  int n_fail   = 0;

  logic bit_q[$];
  logic res_q[$];

  serial_code_controller #(
    .CODE_W     (4),
    .MAX_FAIL   (3),
    .LOCK_CYCLES(16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .code_in   (code_in),
    .relock    (relock),
    .det_g     (det_g),
    .det_in    (det_in),
    .det_rst_n (det_rst_n),
    .busy      (busy),
    .unlocked  (unlocked),
    .fail      (fail),
    .lockout   (lockout),
    .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  // Detector model: matches the last four serial bits against 0110.
  always @(posedge clock) begin
    if (!det_rst_n) det_sr <= '0;
    else            det_sr <= {det_sr[2:0], det_in};
  end
  assign det_g = det_force | (det_sr == 4'b0110);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input bit b, input bit u, input bit f,
                          input bit l, input bit rn, input logic [3:0] fc);
    chk({tag, ".busy"}, 4'(busy), 4'(b));
    chk({tag, ".unlocked"}, 4'(unlocked), 4'(u));
    chk({tag, ".fail"}, 4'(fail), 4'(f));
    chk({tag, ".lockout"}, 4'(lockout), 4'(l));
    chk({tag, ".det_rst_n"}, 4'(det_rst_n), 4'(rn));
    chk({tag, ".fail_count"}, fail_count, fc);
  endtask

  task automatic attempt(input logic [3:0] code, input bit exp_pass, input logic [3:0] prev_fc,
                         input logic [3:0] exp_fc, input bit hold, input bit force_g,
                         input bit to_idle);
    logic exp;
    code_in = code;
    start   = 1'b1;
    for (int i = 3; i >= 0; i--) bit_q.push_back(code[i]);
    res_q.push_back(exp_pass);
    tick();
    if (!hold) start = 1'b0;
    det_force = force_g;
    chk_outs("clear", 1, 0, 0, 0, 0, prev_fc);
    chk("clear.det_in", 4'(det_in), 4'(1));
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_outs("shift", 1, 0, 0, 0, 1, prev_fc);
      chk("shift.det_in", 4'(det_in), 4'(bit_q.pop_front()));
      if (hold) code_in = ~code_in;
      tick();
    end
    det_force = 1'b0;
    chk_outs("check", 1, 0, 0, 0, 1, prev_fc);
    chk("check.det_in", 4'(det_in), 4'(1));
    tick();
    exp = res_q.pop_front();
    if (exp) chk_outs("pass", 0, 1, 0, 0, 0, 4'd0);
    else     chk_outs("fail", 1, 0, 1, 0, 0, exp_fc);
    if (!exp && to_idle) begin
      tick();
      chk_outs("after_fail", 0, 0, 0, 0, 0, exp_fc);
    end
  endtask

  task automatic do_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk_outs("relock", 0, 0, 0, 0, 0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    chk_outs("reset", 0, 0, 0, 0, 0, 4'd0);
    chk("reset.det_in", 4'(det_in), 4'(1));
    reset = 1'b0;
    tick();
    chk_outs("idle", 0, 0, 0, 0, 0, 4'd0);

    // Correct code unlocks, relock returns to idle.
    attempt(4'b0110, 1, 4'd0, 4'd0, 0, 0, 1);
    do_relock();

    // Three failures trigger a 16-cycle lockout; start ignored meanwhile.
    attempt(4'b1111, 0, 4'd0, 4'd1, 0, 0, 1);
    attempt(4'b1111, 0, 4'd1, 4'd2, 0, 0, 1);
    attempt(4'b1111, 0, 4'd2, 4'd3, 0, 0, 0);
    start = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk_outs("lockout", 1, 0, 0, 1, 0, 4'd3);
      if (i == 15) start = 1'b0;
      tick();
    end
    chk_outs("post_lock", 0, 0, 0, 0, 0, 4'd0);
    tick();
    chk_outs("post_lock_idle", 0, 0, 0, 0, 0, 4'd0);

    // Two failures then a pass clears the count without lockout.
    attempt(4'b1111, 0, 4'd0, 4'd1, 0, 0, 1);
    attempt(4'b1010, 0, 4'd1, 4'd2, 0, 0, 1);
    attempt(4'b0110, 1, 4'd2, 4'd0, 0, 0, 1);
    do_relock();

    // det_g forced high outside CHECK must not unlock a wrong code.
    attempt(4'b1001, 0, 4'd0, 4'd1, 0, 1, 1);

    // Asynchronous reset during the second shift cycle.
    code_in = 4'b0110;
    start   = 1'b1;
    for (int i = 3; i >= 0; i--) bit_q.push_back(code_in[i]);
    tick();
    start = 1'b0;
    tick();
    chk("rst_shift1.det_in", 4'(det_in), 4'(bit_q.pop_front()));
    tick();
    chk("rst_shift2.det_in", 4'(det_in), 4'(bit_q.pop_front()));
    #2 reset = 1'b1;
    #1;
    chk_outs("rst_mid", 0, 0, 0, 0, 0, 4'd0);
    chk("rst_mid.det_in", 4'(det_in), 4'(1));
    #2 reset = 1'b0;
    bit_q.delete();
    tick();
    chk_outs("rst_idle", 0, 0, 0, 0, 0, 4'd0);
    attempt(4'b0110, 1, 4'd0, 4'd0, 0, 0, 1);
    do_relock();

    // start held and code_in toggled during the attempt; relock wins over start.
    attempt(4'b0110, 1, 4'd0, 4'd0, 1, 0, 1);
    start  = 1'b1;
    relock = 1'b1;
    tick();
    relock = 1'b0;
    start  = 1'b0;
    chk_outs("relock_start", 0, 0, 0, 0, 0, 4'd0);
    tick();
    chk_outs("relock_idle", 0, 0, 0, 0, 0, 4'd0);

    chk("sb_bits_empty", 4'(bit_q.size()), 4'd0);
    chk("sb_res_empty", 4'(res_q.size()), 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
